lift_car_scheduler: RTL and testbench

Parametrised single-car lift controller core that drives the car-side signals of the lift controller interface (direction, motion, door_open) from latched hall and car requests.
- Direction-collective (SCAN) scheduling; door dwell timer with force-open extension.
- Per-floor pending-request lamp outputs.
- Motion watchdog that parks the car in FAULT.
- Sits between the floor button/sensor fabric and the motor/door actuators.

---
 rtl/lift_car_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_lift_car_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lift_car_scheduler.sv
// Single-car direction-collective lift controller: latches hall/car requests,
// schedules MOVE/OPEN with a door dwell timer and a motion watchdog.
module lift_car_scheduler #(
  parameter int N_FLOORS     = 8,
  parameter int DOOR_CYCLES  = 64,
  parameter int MOVE_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         up_rqst,
  input  logic [N_FLOORS-1:0]         dn_rqst,
  input  logic [N_FLOORS-1:0]         flr_rqst,
  input  logic                        force_open,
  input  logic [N_FLOORS-1:0]         floor_sense,
  output logic                        direction,
  output logic                        motion,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pend_up,
  output logic [N_FLOORS-1:0]         pend_dn,
  output logic [N_FLOORS-1:0]         pend_car,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic                        fault
);

  localparam int FW = $clog2(N_FLOORS);
  localparam int TW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam int WW = (MOVE_TIMEOUT > 2) ? $clog2(MOVE_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, OPEN, MOVE, FAULT} state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic                motion_q, door_q, fault_q;
  logic [N_FLOORS-1:0] pend_up_q, pend_up_d;
  logic [N_FLOORS-1:0] pend_dn_q, pend_dn_d;
  logic [N_FLOORS-1:0] pend_car_q, pend_car_d;
  logic [FW-1:0]       cur_floor_q, cur_floor_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic [N_FLOORS-1:0] sense_q;

  logic [N_FLOORS-1:0] all_pend, ef_mask;
  logic [N_FLOORS-1:0] set_up, set_dn, set_car, clr_up, clr_dn, clr_car;
  logic [FW-1:0]       sense_idx, ef;
  logic                multi, arrive, ahead, behind, here_srv, beyond, terminal;

  function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if ((i > int'(idx)) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if ((i < int'(idx)) && v[i]) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    all_pend  = pend_up_q | pend_dn_q | pend_car_q;
    multi     = |(floor_sense & (floor_sense - 1'b1));
    sense_idx = '0;
    for (int i = 0; i < N_FLOORS; i++)
      if (floor_sense[i]) sense_idx = FW'(i);
    arrive      = (floor_sense != '0) && !multi && (floor_sense != sense_q);
    cur_floor_d = arrive ? sense_idx : cur_floor_q;

    ahead  = dir_q ? any_above(all_pend, cur_floor_q) : any_below(all_pend, cur_floor_q);
    behind = dir_q ? any_below(all_pend, cur_floor_q) : any_above(all_pend, cur_floor_q);
    // An opposite-direction hall call here is deferred while work remains ahead,
    // otherwise IDLE would reopen the door forever instead of continuing the sweep.
    here_srv = pend_car_q[cur_floor_q]
             | (dir_q ? pend_up_q[cur_floor_q] : pend_dn_q[cur_floor_q])
             | ((dir_q ? pend_dn_q[cur_floor_q] : pend_up_q[cur_floor_q]) & !ahead);

    state_d  = state_q;
    dir_d    = dir_q;
    tmr_d    = tmr_q;
    wd_d     = wd_q;
    set_up   = up_rqst;
    set_dn   = dn_rqst;
    set_car  = flr_rqst;
    clr_up   = '0;
    clr_dn   = '0;
    clr_car  = '0;
    beyond   = 1'b0;
    terminal = 1'b0;
    ef       = cur_floor_d;
    ef_mask  = '0;

    case (state_q)
      IDLE: begin
        if (force_open || here_srv) begin
          state_d = OPEN;
        end else if (ahead) begin
          state_d = MOVE;
        end else if (behind) begin
          state_d = MOVE;
          dir_d   = !dir_q;
        end
      end
      MOVE: begin
        if (arrive) begin
          wd_d     = '0;
          beyond   = dir_q ? any_above(all_pend, sense_idx) : any_below(all_pend, sense_idx);
          terminal = dir_q ? (sense_idx == FW'(N_FLOORS - 1)) : (sense_idx == '0);
          if (pend_car_q[sense_idx] || (dir_q && pend_up_q[sense_idx]) ||
              (!dir_q && pend_dn_q[sense_idx]) || !beyond || terminal)
            state_d = OPEN;
        end else if (wd_q == WW'(MOVE_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      OPEN: begin
        if (force_open || flr_rqst[cur_floor_q] ||
            (dir_q ? up_rqst[cur_floor_q] : dn_rqst[cur_floor_q]))
          tmr_d = TW'(DOOR_CYCLES - 1);
        else if (tmr_q == '0)
          state_d = IDLE;
        else
          tmr_d = tmr_q - 1'b1;
        // Requests matching the current dwell are served by the open door.
        set_car[cur_floor_q] = 1'b0;
        if (dir_q) set_up[cur_floor_q] = 1'b0;
        else       set_dn[cur_floor_q] = 1'b0;
      end
      default: ;
    endcase

    if (multi) state_d = FAULT;

    if ((state_d == OPEN) && (state_q != OPEN)) begin
      tmr_d       = TW'(DOOR_CYCLES - 1);
      ef_mask[ef] = 1'b1;
      clr_car[ef] = 1'b1;
      set_car[ef] = 1'b0;
      if (dir_d) begin
        clr_up[ef] = 1'b1;
        set_up[ef] = 1'b0;
      end else begin
        clr_dn[ef] = 1'b1;
        set_dn[ef] = 1'b0;
      end
      beyond = dir_d ? any_above(all_pend, ef) : any_below(all_pend, ef);
      if (!(|(all_pend & ~ef_mask))) begin
        clr_up[ef] = 1'b1;
        clr_dn[ef] = 1'b1;
      end else if ((dir_d ? pend_dn_q[ef] : pend_up_q[ef]) && !beyond) begin
        if (dir_d) clr_dn[ef] = 1'b1;
        else       clr_up[ef] = 1'b1;
        dir_d = !dir_d;
      end
    end

    if ((state_d == MOVE) && (state_q != MOVE)) wd_d = '0;

    pend_up_d  = (pend_up_q  & ~clr_up)  | set_up;
    pend_dn_d  = (pend_dn_q  & ~clr_dn)  | set_dn;
    pend_car_d = (pend_car_q & ~clr_car) | set_car;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      motion_q    <= 1'b0;
      door_q      <= 1'b0;
      fault_q     <= 1'b0;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      pend_car_q  <= '0;
      cur_floor_q <= '0;
      tmr_q       <= '0;
      wd_q        <= '0;
      sense_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      motion_q    <= (state_d == MOVE);
      door_q      <= (state_d == OPEN);
      fault_q     <= (state_d == FAULT);
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_car_q  <= pend_car_d;
      cur_floor_q <= cur_floor_d;
      tmr_q       <= tmr_d;
      wd_q        <= wd_d;
      sense_q     <= floor_sense;
    end
  end

  assign direction = dir_q;
  assign motion    = motion_q;
  assign door_open = door_q;
  assign pend_up   = pend_up_q;
  assign pend_dn   = pend_dn_q;
  assign pend_car  = pend_car_q;
  assign cur_floor = cur_floor_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_lift_car_scheduler.sv
// Directed scoreboard bench for lift_car_scheduler with 4 floors, 8-cycle dwell
// and 16-cycle watchdog; each expected snapshot is queued then compared.
module tb_lift_car_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] up_rqst, dn_rqst, flr_rqst, floor_sense;
  logic       force_open;
  logic       direction, motion, door_open, fault;
  logic [3:0] pend_up, pend_dn, pend_car;
  logic [1:0] cur_floor;

  always #5 clk = ~clk;

  lift_car_scheduler #(.N_FLOORS(4), .DOOR_CYCLES(8), .MOVE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .up_rqst(up_rqst), .dn_rqst(dn_rqst), .flr_rqst(flr_rqst),
    .force_open(force_open), .floor_sense(floor_sense), .direction(direction),
    .motion(motion), .door_open(door_open), .pend_up(pend_up), .pend_dn(pend_dn),
    .pend_car(pend_car), .cur_floor(cur_floor), .fault(fault)
  );

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Snapshot layout: fault, direction, motion, door_open, cur_floor, pend_up, pend_dn, pend_car
  function automatic logic [17:0] snap(input logic f, input logic d, input logic m, input logic o,
                                       input logic [1:0] cf, input logic [3:0] pu,
                                       input logic [3:0] pd, input logic [3:0] pc);
    return {f, d, m, o, cf, pu, pd, pc};
  endfunction

  task automatic expect_state(input string tag, input logic [17:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t        e;
    logic [17:0] obs;
    e   = sb.pop_front();
    obs = snap(fault, direction, motion, door_open, cur_floor, pend_up, pend_dn, pend_car);
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] v);
    expect_state(tag, v);
    compare_out();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c, input logic fo);
    up_rqst = u; dn_rqst = d; flr_rqst = c; force_open = fo;
    tick(1);
    up_rqst = '0; dn_rqst = '0; flr_rqst = '0; force_open = 1'b0;
  endtask

  task automatic move_to(input int f);
    floor_sense = 4'b0000;
    tick(1);
    floor_sense = 4'b0001 << f;
    tick(1);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 chk(tag, snap(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
    floor_sense = 4'b0001;
    @(negedge clk);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    reset = 1'b0; up_rqst = '0; dn_rqst = '0; flr_rqst = '0; force_open = 1'b0;
    floor_sense = 4'b0001;
    tick(2);
    chk("reset_state", snap(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
    reset = 1'b1;
    tick(2);
    chk("idle_after_reset", snap(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));

    // Car call to the top floor passes 1 and 2 without stopping.
    pulse(4'h0, 4'h0, 4'h8, 1'b0);
    chk("t1_latch", snap(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h8));
    tick(1);
    chk("t1_move", snap(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h8));
    move_to(1);
    chk("t1_pass1", snap(0, 1, 1, 0, 1, 4'h0, 4'h0, 4'h8));
    move_to(2);
    chk("t1_pass2", snap(0, 1, 1, 0, 2, 4'h0, 4'h0, 4'h8));
    move_to(3);
    chk("t1_stop3", snap(0, 1, 0, 1, 3, 4'h0, 4'h0, 4'h0));
    tick(7);
    chk("t1_dwell_end", snap(0, 1, 0, 1, 3, 4'h0, 4'h0, 4'h0));
    tick(1);
    chk("t1_door_closed", snap(0, 1, 0, 0, 3, 4'h0, 4'h0, 4'h0));

    // Return to floor 0.
    pulse(4'h0, 4'h0, 4'h1, 1'b0);
    tick(1);
    chk("ret_move_down", snap(0, 0, 1, 0, 3, 4'h0, 4'h0, 4'h1));
    move_to(2);
    move_to(1);
    move_to(0);
    chk("ret_stop0", snap(0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0));
    tick(8);
    chk("ret_idle0", snap(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0));

    // Collective up sweep with a hall up at 2 and hall down at 1.
    pulse(4'h0, 4'h0, 4'h8, 1'b0);
    chk("t2_latch", snap(0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h8));
    tick(1);
    chk("t2_move_flip_up", snap(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h8));
    floor_sense = 4'b0000;
    pulse(4'h4, 4'h0, 4'h0, 1'b0);
    pulse(4'h0, 4'h2, 4'h0, 1'b0);
    chk("t2_hall_latched", snap(0, 1, 1, 0, 0, 4'h4, 4'h2, 4'h8));
    floor_sense = 4'b0010;
    tick(1);
    chk("t2_pass1", snap(0, 1, 1, 0, 1, 4'h4, 4'h2, 4'h8));
    move_to(2);
    chk("t2_stop2", snap(0, 1, 0, 1, 2, 4'h0, 4'h2, 4'h8));
    tick(8);
    chk("t2_close2", snap(0, 1, 0, 0, 2, 4'h0, 4'h2, 4'h8));
    tick(1);
    chk("t2_resume", snap(0, 1, 1, 0, 2, 4'h0, 4'h2, 4'h8));
    move_to(3);
    chk("t2_stop3", snap(0, 1, 0, 1, 3, 4'h0, 4'h2, 4'h0));
    tick(8);
    chk("t2_close3", snap(0, 1, 0, 0, 3, 4'h0, 4'h2, 4'h0));
    tick(1);
    chk("t2_reverse", snap(0, 0, 1, 0, 3, 4'h0, 4'h2, 4'h0));
    move_to(2);
    chk("t2_pass2_down", snap(0, 0, 1, 0, 2, 4'h0, 4'h2, 4'h0));
    move_to(1);
    chk("t2_stop1", snap(0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0));

    // Matching hall call during dwell reloads; opposite one latches.
    tick(3);
    pulse(4'h2, 4'h2, 4'h0, 1'b0);
    chk("t6m_reload", snap(0, 0, 0, 1, 1, 4'h2, 4'h0, 4'h0));
    tick(7);
    chk("t6m_still_open", snap(0, 0, 0, 1, 1, 4'h2, 4'h0, 4'h0));
    tick(1);
    chk("t6m_closed", snap(0, 0, 0, 0, 1, 4'h2, 4'h0, 4'h0));
    tick(1);
    chk("t6m_reopen", snap(0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0));
    tick(8);
    chk("t6m_idle", snap(0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0));

    // Force-open dwell with an extension at dwell cycle 5.
    pulse(4'h0, 4'h0, 4'h4, 1'b0);
    tick(1);
    chk("t3_move", snap(0, 1, 1, 0, 1, 4'h0, 4'h0, 4'h4));
    move_to(2);
    chk("t3_stop2", snap(0, 1, 0, 1, 2, 4'h0, 4'h0, 4'h0));
    tick(8);
    chk("t3_idle2", snap(0, 1, 0, 0, 2, 4'h0, 4'h0, 4'h0));
    pulse(4'h0, 4'h0, 4'h0, 1'b1);
    chk("t3_fo_open", snap(0, 1, 0, 1, 2, 4'h0, 4'h0, 4'h0));
    tick(3);
    pulse(4'h0, 4'h0, 4'h0, 1'b1);
    tick(4);
    chk("t3_extended", snap(0, 1, 0, 1, 2, 4'h0, 4'h0, 4'h0));
    tick(3);
    chk("t3_ext_last", snap(0, 1, 0, 1, 2, 4'h0, 4'h0, 4'h0));
    tick(1);
    chk("t3_ext_closed", snap(0, 1, 0, 0, 2, 4'h0, 4'h0, 4'h0));

    // Watchdog: no arrival for 16 cycles.
    pulse(4'h0, 4'h0, 4'h1, 1'b0);
    tick(1);
    chk("t4_move", snap(0, 0, 1, 0, 2, 4'h0, 4'h0, 4'h1));
    floor_sense = 4'b0000;
    tick(15);
    chk("t4_wd_15", snap(0, 0, 1, 0, 2, 4'h0, 4'h0, 4'h1));
    tick(1);
    chk("t4_wd_fault", snap(1, 0, 0, 0, 2, 4'h0, 4'h0, 4'h1));
    pulse(4'h8, 4'h0, 4'h0, 1'b0);
    chk("t4_fault_latch", snap(1, 0, 0, 0, 2, 4'h8, 4'h0, 4'h1));
    tick(3);
    chk("t4_fault_stuck", snap(1, 0, 0, 0, 2, 4'h8, 4'h0, 4'h1));
    async_reset("t4_async_reset");
    chk("t4_idle", snap(0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));

    // Multi-bit floor sense.
    floor_sense = 4'b0110;
    tick(1);
    chk("t5_multi_fault", snap(1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0));
    async_reset("t5_async_reset");

    // At floor 1 going up: hall up reloads, hall down latches.
    pulse(4'h0, 4'h0, 4'h2, 1'b0);
    tick(1);
    chk("t6_move", snap(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h2));
    move_to(1);
    chk("t6_stop1", snap(0, 1, 0, 1, 1, 4'h0, 4'h0, 4'h0));
    tick(2);
    pulse(4'h2, 4'h2, 4'h0, 1'b0);
    chk("t6_reload", snap(0, 1, 0, 1, 1, 4'h0, 4'h2, 4'h0));
    tick(7);
    chk("t6_still_open", snap(0, 1, 0, 1, 1, 4'h0, 4'h2, 4'h0));
    tick(1);
    chk("t6_closed", snap(0, 1, 0, 0, 1, 4'h0, 4'h2, 4'h0));
    tick(1);
    chk("t6_reopen", snap(0, 1, 0, 1, 1, 4'h0, 4'h0, 4'h0));
    tick(8);
    chk("t6_idle", snap(0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0));

    // Reset mid-MOVE drops motion without a clock edge.
    pulse(4'h0, 4'h0, 4'h1, 1'b0);
    tick(1);
    chk("t7_move", snap(0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h1));
    floor_sense = 4'b0000;
    tick(1);
    chk("t7_between", snap(0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h1));
    async_reset("t7_async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
